// File: rtl/digital_clock_pkg.sv
// Shared definitions for the stopwatch display path.
//   CS_PER_SEC / CS_PER_MIN / CS_PER_HR : centisecond weights of each field
//   state_t    : converter FSM states (ST_DIV_HR only used with DIGITAL_CLOCK_HOUR_EN)
//   bcd_pair_t : one display field as {tens, units}
package digital_clock_pkg;

    localparam int unsigned CS_PER_SEC = 100;
    localparam int unsigned CS_PER_MIN = 6000;
    localparam int unsigned CS_PER_HR  = 360000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DIV_HR,
        ST_DIV_MIN,
        ST_DIV_SEC,
        ST_SPLIT,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] units;
    } bcd_pair_t;

endpackage

// File: rtl/bcd_split_99.sv
// Sequential 0..99 -> {tens, units} splitter.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : load `value` and restart the split (one cycle)
//   value      : binary value 0..99
//   tens/units : BCD digits, final once `done` is high
//   done       : remainder below ten and no load in progress
module bcd_split_99 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [6:0] value,
    output logic [3:0] tens,
    output logic [3:0] units,
    output logic       done
);

    logic [6:0] rem;
    logic [3:0] tens_q;

    // One subtraction of ten per cycle after the load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem    <= '0;
            tens_q <= '0;
        end else if (start) begin
            rem    <= value;
            tens_q <= '0;
        end else if (rem >= 7'd10) begin
            rem    <= rem - 7'd10;
            tens_q <= tens_q + 4'd1;
        end
    end

    assign tens  = tens_q;
    assign units = rem[3:0];
    assign done  = (rem < 7'd10) && !start;

endmodule

// File: rtl/cs_time_to_bcd.sv
// Converts the stopwatch centisecond count into BCD mm:ss.cc for the
// seven-segment scan driver. The slow count is double-sampled, captured when
// stable and changed, then divided by repeated subtraction and split to BCD.
// Optional feature macro: DIGITAL_CLOCK_HOUR_EN (adds bcd_hh and hour stage).
//   clk_100MHz : system clock
//   rst_n      : asynchronous active-low reset
//   data_1h    : binary centisecond count (changes at most once per 10 ms)
//   bcd_hh     : hours {tens, units} (DIGITAL_CLOCK_HOUR_EN only)
//   bcd_mm     : minutes {tens, units}
//   bcd_ss     : seconds {tens, units}
//   bcd_cc     : centiseconds {tens, units}
//   valid      : one-cycle pulse when new digits are loaded
//   busy       : high from capture through DONE
//   ovf        : last captured value was >= MAX_CS (digits saturated)
module cs_time_to_bcd
    import digital_clock_pkg::*;
#(
    parameter int unsigned IN_W   = 32,
`ifdef DIGITAL_CLOCK_HOUR_EN
    parameter int unsigned MAX_CS = 36000000
`else
    parameter int unsigned MAX_CS = 360000
`endif
) (
    input  logic            clk_100MHz,
    input  logic            rst_n,
    input  logic [IN_W-1:0] data_1h,
`ifdef DIGITAL_CLOCK_HOUR_EN
    output logic [7:0]      bcd_hh,
`endif
    output logic [7:0]      bcd_mm,
    output logic [7:0]      bcd_ss,
    output logic [7:0]      bcd_cc,
    output logic            valid,
    output logic            busy,
    output logic            ovf
);

    localparam logic [IN_W-1:0] SEC_STEP = IN_W'(CS_PER_SEC);
    localparam logic [IN_W-1:0] MIN_STEP = IN_W'(CS_PER_MIN);
    localparam logic [IN_W-1:0] MAX_LIM  = IN_W'(MAX_CS);
`ifdef DIGITAL_CLOCK_HOUR_EN
    localparam logic [IN_W-1:0] HR_STEP   = IN_W'(CS_PER_HR);
    localparam state_t          FIRST_DIV = ST_DIV_HR;
`else
    localparam state_t          FIRST_DIV = ST_DIV_MIN;
`endif

    state_t          state;
    logic [IN_W-1:0] s1, s2;
    logic [IN_W-1:0] last_val;
    logic [IN_W-1:0] cap_val;
    logic [IN_W-1:0] rem;
    logic [6:0]      min_cnt, sec_cnt;
    logic            ovf_pend;

    bcd_pair_t       min_bcd, sec_bcd, cc_bcd;
    logic            min_done, sec_done, cc_done;
    logic            split_start, split_done;

`ifdef DIGITAL_CLOCK_HOUR_EN
    logic [6:0]      hr_cnt;
    bcd_pair_t       hr_bcd;
    logic            hr_done;
`endif

    // Splitters load on the edge that leaves DIV_SEC, when every count is final.
    assign split_start = (state == ST_DIV_SEC) && (rem < SEC_STEP);

    bcd_split_99 u_split_min (
        .clk   (clk_100MHz),
        .rst_n (rst_n),
        .start (split_start),
        .value (min_cnt),
        .tens  (min_bcd.tens),
        .units (min_bcd.units),
        .done  (min_done)
    );

    bcd_split_99 u_split_sec (
        .clk   (clk_100MHz),
        .rst_n (rst_n),
        .start (split_start),
        .value (sec_cnt),
        .tens  (sec_bcd.tens),
        .units (sec_bcd.units),
        .done  (sec_done)
    );

    bcd_split_99 u_split_cc (
        .clk   (clk_100MHz),
        .rst_n (rst_n),
        .start (split_start),
        .value (rem[6:0]),
        .tens  (cc_bcd.tens),
        .units (cc_bcd.units),
        .done  (cc_done)
    );

`ifdef DIGITAL_CLOCK_HOUR_EN
    bcd_split_99 u_split_hr (
        .clk   (clk_100MHz),
        .rst_n (rst_n),
        .start (split_start),
        .value (hr_cnt),
        .tens  (hr_bcd.tens),
        .units (hr_bcd.units),
        .done  (hr_done)
    );

    assign split_done = hr_done && min_done && sec_done && cc_done;
`else
    assign split_done = min_done && sec_done && cc_done;
`endif

    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            s1       <= '0;
            s2       <= '0;
            last_val <= '0;
            cap_val  <= '0;
            rem      <= '0;
            min_cnt  <= '0;
            sec_cnt  <= '0;
            ovf_pend <= 1'b0;
            bcd_mm   <= '0;
            bcd_ss   <= '0;
            bcd_cc   <= '0;
            valid    <= 1'b0;
            busy     <= 1'b0;
            ovf      <= 1'b0;
`ifdef DIGITAL_CLOCK_HOUR_EN
            hr_cnt   <= '0;
            bcd_hh   <= '0;
`endif
        end else begin
            s1    <= data_1h;
            s2    <= s1;
            valid <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if ((s1 == s2) && (s2 != last_val)) begin
                        rem     <= s2;
                        cap_val <= s2;
                        min_cnt <= '0;
                        sec_cnt <= '0;
`ifdef DIGITAL_CLOCK_HOUR_EN
                        hr_cnt  <= '0;
`endif
                        busy    <= 1'b1;
                        if (s2 >= MAX_LIM) begin
                            ovf_pend <= 1'b1;
                            state    <= ST_DONE;
                        end else begin
                            ovf_pend <= 1'b0;
                            state    <= FIRST_DIV;
                        end
                    end
                end

`ifdef DIGITAL_CLOCK_HOUR_EN
                ST_DIV_HR: begin
                    if (rem >= HR_STEP) begin
                        rem    <= rem - HR_STEP;
                        hr_cnt <= hr_cnt + 7'd1;
                    end else begin
                        state <= ST_DIV_MIN;
                    end
                end
`endif

                ST_DIV_MIN: begin
                    if (rem >= MIN_STEP) begin
                        rem     <= rem - MIN_STEP;
                        min_cnt <= min_cnt + 7'd1;
                    end else begin
                        state <= ST_DIV_SEC;
                    end
                end

                ST_DIV_SEC: begin
                    if (rem >= SEC_STEP) begin
                        rem     <= rem - SEC_STEP;
                        sec_cnt <= sec_cnt + 7'd1;
                    end else begin
                        state <= ST_SPLIT;
                    end
                end

                ST_SPLIT: begin
                    if (split_done) begin
                        state <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    if (ovf_pend) begin
                        bcd_mm <= 8'h59;
                        bcd_ss <= 8'h59;
                        bcd_cc <= 8'h99;
`ifdef DIGITAL_CLOCK_HOUR_EN
                        bcd_hh <= 8'h99;
`endif
                    end else begin
                        bcd_mm <= min_bcd;
                        bcd_ss <= sec_bcd;
                        bcd_cc <= cc_bcd;
`ifdef DIGITAL_CLOCK_HOUR_EN
                        bcd_hh <= hr_bcd;
`endif
                    end
                    ovf      <= ovf_pend;
                    valid    <= 1'b1;
                    busy     <= 1'b0;
                    last_val <= cap_val;
                    state    <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cs_time_to_bcd.sv
`timescale 1ns/1ps
module tb_cs_time_to_bcd;

    localparam int unsigned IN_W = 32;
`ifdef DIGITAL_CLOCK_HOUR_EN
    localparam int unsigned MAX_CS = 36000000;
`else
    localparam int unsigned MAX_CS = 360000;
`endif
    localparam int WIN = 150;

    logic            clk_100MHz = 1'b0;
    logic            rst_n;
    logic [IN_W-1:0] data_1h;
    logic [7:0]      bcd_mm, bcd_ss, bcd_cc;
    logic            valid, busy, ovf;
`ifdef DIGITAL_CLOCK_HOUR_EN
    logic [7:0]      bcd_hh;
`else
    logic [7:0]      bcd_hh;
    assign bcd_hh = 8'h00;
`endif

    always #5 clk_100MHz = ~clk_100MHz;

    cs_time_to_bcd #(.IN_W(IN_W), .MAX_CS(MAX_CS)) dut (
        .clk_100MHz (clk_100MHz),
        .rst_n      (rst_n),
        .data_1h    (data_1h),
`ifdef DIGITAL_CLOCK_HOUR_EN
        .bcd_hh     (bcd_hh),
`endif
        .bcd_mm     (bcd_mm),
        .bcd_ss     (bcd_ss),
        .bcd_cc     (bcd_cc),
        .valid      (valid),
        .busy       (busy),
        .ovf        (ovf)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    int unsigned last_cap = 0;

    // Observation window results
    int         p_cnt, hold_err, busy_cnt;
    logic       busy_at3;
    int         p_edge [4];
    logic [7:0] p_hh [4], p_mm [4], p_ss [4], p_cc [4];
    logic       p_ovf [4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] bcd2(input int unsigned x);
        return 8'(((x / 10) << 4) | (x % 10));
    endfunction

    // Reference: digits by plain division, latency from the per-state cycle rules.
    function automatic void model(input int unsigned v,
                                  output logic [7:0] e_hh, output logic [7:0] e_mm,
                                  output logic [7:0] e_ss, output logic [7:0] e_cc,
                                  output logic e_ovf, output int e_lat);
        int unsigned h, m, s, c, t;
        if (v >= MAX_CS) begin
            e_hh = 8'h99; e_mm = 8'h59; e_ss = 8'h59; e_cc = 8'h99;
            e_ovf = 1'b1; e_lat = 4;
            return;
        end
        h = 0;
`ifdef DIGITAL_CLOCK_HOUR_EN
        h = v / 360000;
        m = (v % 360000) / 6000;
`else
        m = v / 6000;
`endif
        s = (v % 6000) / 100;
        c = v % 100;
        t = m / 10;
        if (s / 10 > t) t = s / 10;
        if (c / 10 > t) t = c / 10;
        if (h / 10 > t) t = h / 10;
        e_lat = int'(3 + (m + 1) + (s + 1) + (t + 1) + 1);
`ifdef DIGITAL_CLOCK_HOUR_EN
        e_lat = e_lat + int'(h + 1);
`endif
        e_hh = bcd2(h); e_mm = bcd2(m); e_ss = bcd2(s); e_cc = bcd2(c);
        e_ovf = 1'b0;
    endfunction

    // Watch n posedges (edge 1 = first edge after the call), sampling 1 ns later.
    task automatic watch(input int n_edges);
        logic [7:0] pm, ps, pc, ph;
        logic       po;
        p_cnt = 0; hold_err = 0; busy_cnt = 0; busy_at3 = 1'b0;
        for (int i = 0; i < 4; i++) p_edge[i] = 0;
        pm = bcd_mm; ps = bcd_ss; pc = bcd_cc; ph = bcd_hh; po = ovf;
        for (int k = 1; k <= n_edges; k++) begin
            @(posedge clk_100MHz);
            #1;
            if (busy) busy_cnt++;
            if (k == 3) busy_at3 = busy;
            if (valid) begin
                if (p_cnt < 4) begin
                    p_edge[p_cnt] = k;
                    p_hh[p_cnt] = bcd_hh; p_mm[p_cnt] = bcd_mm;
                    p_ss[p_cnt] = bcd_ss; p_cc[p_cnt] = bcd_cc;
                    p_ovf[p_cnt] = ovf;
                end
                p_cnt++;
            end else if (bcd_mm !== pm || bcd_ss !== ps || bcd_cc !== pc ||
                         bcd_hh !== ph || ovf !== po) begin
                hold_err++;
            end
            pm = bcd_mm; ps = bcd_ss; pc = bcd_cc; ph = bcd_hh; po = ovf;
        end
    endtask

    task automatic convert(input int unsigned v);
        logic [7:0] e_hh, e_mm, e_ss, e_cc;
        logic       e_ovf;
        int         e_lat;
        logic       exp_pulse;
        model(v, e_hh, e_mm, e_ss, e_cc, e_ovf, e_lat);
        exp_pulse = (v != last_cap);
        @(negedge clk_100MHz);
        data_1h = v;
        watch(WIN);
        if (exp_pulse) begin
            check($sformatf("pulses[%0d]", v), 32'(p_cnt), 32'd1);
            check($sformatf("latency[%0d]", v), 32'(p_edge[0]), 32'(e_lat));
            check($sformatf("mm[%0d]", v), 32'(p_mm[0]), 32'(e_mm));
            check($sformatf("ss[%0d]", v), 32'(p_ss[0]), 32'(e_ss));
            check($sformatf("cc[%0d]", v), 32'(p_cc[0]), 32'(e_cc));
            check($sformatf("ovf[%0d]", v), 32'(p_ovf[0]), 32'(e_ovf));
`ifdef DIGITAL_CLOCK_HOUR_EN
            check($sformatf("hh[%0d]", v), 32'(p_hh[0]), 32'(e_hh));
`endif
            check($sformatf("busy_at_capture[%0d]", v), 32'(busy_at3), 32'd1);
            check($sformatf("busy_cycles[%0d]", v), 32'(busy_cnt), 32'(e_lat - 3));
            last_cap = v;
        end else begin
            check($sformatf("no_pulse[%0d]", v), 32'(p_cnt), 32'd0);
        end
        check($sformatf("hold[%0d]", v), 32'(hold_err), 32'd0);
        check($sformatf("busy_idle[%0d]", v), 32'(busy), 32'd0);
    endtask

    initial begin
        int unsigned v;
        int          lat5999;
        logic [7:0]  t_hh, t_mm, t_ss, t_cc;
        logic        t_ovf;

        // Reset, then hold 0: nothing happens.
        rst_n   = 1'b0;
        data_1h = '0;
        #12;
        check("rst_mm", 32'(bcd_mm), 32'd0);
        check("rst_flags", 32'({valid, busy, ovf}), 32'd0);
        @(negedge clk_100MHz);
        rst_n = 1'b1;
        watch(40);
        check("zero_no_pulse", 32'(p_cnt), 32'd0);
        check("zero_busy", 32'(busy_cnt), 32'd0);
        check("zero_digits", 32'({bcd_mm, bcd_ss, bcd_cc}), 32'd0);
        check("zero_ovf", 32'(ovf), 32'd0);

        // Directed vectors and boundaries.
        convert(12345);
        convert(12345);          // unchanged value: no pulse
        convert(359999);
        convert(360000);
        convert(100);
        convert(0);
`ifdef DIGITAL_CLOCK_HOUR_EN
        convert(372345);
        convert(MAX_CS - 1);
        convert(MAX_CS);
`endif

        // Input change while busy: both values converted in order.
        model(5999, t_hh, t_mm, t_ss, t_cc, t_ovf, lat5999);
        @(negedge clk_100MHz);
        data_1h = 5999;
        repeat (10) @(negedge clk_100MHz);
        check("midchg_busy", 32'(busy), 32'd1);
        data_1h = 6000;
        watch(WIN);
        check("midchg_pulses", 32'(p_cnt), 32'd2);
        check("midchg_first_edge", 32'(p_edge[0]), 32'(lat5999 - 10));
        check("midchg_first", 32'({p_mm[0], p_ss[0], p_cc[0]}), 32'h005999);
        check("midchg_second", 32'({p_mm[1], p_ss[1], p_cc[1]}), 32'h010000);
        check("midchg_hold", 32'(hold_err), 32'd0);
        last_cap = 6000;

        // Reset in the middle of DIV_MIN.
        @(negedge clk_100MHz);
        data_1h = 300000;
        repeat (10) @(posedge clk_100MHz);
        #3;
        check("prerst_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("asyncrst_digits", 32'({bcd_mm, bcd_ss, bcd_cc}), 32'd0);
        check("asyncrst_flags", 32'({valid, busy, ovf}), 32'd0);
        data_1h = 6000;
        @(negedge clk_100MHz);
        rst_n = 1'b1;
        last_cap = 0;
        watch(WIN);
        check("postrst_pulses", 32'(p_cnt), 32'd1);
        check("postrst_latency", 32'(p_edge[0]), 32'd8);
        check("postrst_digits", 32'({p_mm[0], p_ss[0], p_cc[0]}), 32'h010000);
        last_cap = 6000;

        // Randomized values, some beyond range.
        for (int i = 0; i < 24; i++) begin
            if (i % 6 == 5)
                v = $urandom_range(MAX_CS + 200000, MAX_CS);
            else
                v = $urandom_range(MAX_CS - 1, 0);
            convert(v);
        end
        convert(MAX_CS - 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
